// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: requester, response and multiplier-side signals of mul_arbiter.
interface mul_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic resp_valid;
    logic [IW-1:0] resp_id;
    logic [63:0] resp_product;
    logic resp_error;
    logic resp_ready;
    logic mul_start;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [63:0] mul_product;
    logic mul_finish;
    logic busy;
    modport slave (
        input req_valid, req_a, req_b, resp_ready, mul_product, mul_finish,
        output req_ready, resp_valid, resp_id, resp_product, resp_error,
        output mul_start, mul_multiplicand, mul_multiplier, busy
    );
    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_product, mul_finish,
        input req_ready, resp_valid, resp_id, resp_product, resp_error,
        input mul_start, mul_multiplicand, mul_multiplier, busy
    );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one sequential 32x32 multiplier among NREQ requesters,
// with zero-operand bypass and a finish timeout.
module mul_arbiter #(
    parameter int NREQ = 4,
    parameter int TIMEOUT = 48
) (
    input logic clk,
    input logic rst,
    mul_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;
    state_t state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic found;
    logic [CW-1:0] cnt;
    logic [31:0] a;
    logic [31:0] b;
    logic timeout;
    always_comb begin
        win = '0;
        found = 1'b0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end
    assign a = bus.req_a[{win, 5'd0} +: 32];
    assign b = bus.req_b[{win, 5'd0} +: 32];
    assign bus.req_ready = (state == IDLE && found) ? NREQ'(1) << win : '0;
    assign timeout = cnt >= CW'(TIMEOUT - 1);
    // ARM exists only to let a finish left high by the previous operation drop first
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id <= '0;
            bus.resp_product <= '0;
            bus.resp_error <= 1'b0;
            bus.mul_start <= 1'b0;
            bus.mul_multiplicand <= '0;
            bus.mul_multiplier <= '0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    bus.mul_multiplicand <= a;
                    bus.mul_multiplier <= b;
                    bus.resp_id <= win;
                    ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                    bus.busy <= 1'b1;
                    if (a == '0 || b == '0) begin
                        bus.resp_product <= '0;
                        bus.resp_error <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        bus.mul_start <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mul_start <= 1'b0;
                    cnt <= '0;
                    state <= ARM;
                end
                ARM: begin
                    cnt <= cnt + 1'b1;
                    if (!bus.mul_finish) begin
                        state <= WAIT;
                    end else if (timeout) begin
                        bus.resp_product <= '0;
                        bus.resp_error <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state <= RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mul_finish) begin
                        bus.resp_product <= bus.mul_product;
                        bus.resp_error <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state <= RESP;
                    end else if (timeout) begin
                        bus.resp_product <= '0;
                        bus.resp_error <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed tests of mul_arbiter against a cycle-timing scoreboard model
// and a latency-configurable multiplier model.
module tb_mul_arbiter;
    localparam int NREQ = 4;
    localparam int TIMEOUT = 48;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int starts = 0;
    mul_arbiter_if #(.NREQ(NREQ)) bus ();
    mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // multiplier model: finish low from start+1, product published when finish rises at start+lat
    int lat = 5;
    bit never = 1'b0;
    int mcnt = 0;
    logic m_fin = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pend = '0;
    assign bus.mul_finish = m_fin;
    assign bus.mul_product = m_prod;
    always @(posedge clk) begin
        if (bus.mul_start) begin
            m_fin <= 1'b0;
            mcnt <= lat - 1;
            m_pend <= 64'(bus.mul_multiplicand) * 64'(bus.mul_multiplier);
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !never) begin
                m_fin <= 1'b1;
                m_prod <= m_pend;
            end
        end
    end
    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction
    // scoreboard: accept at cycle T -> response from T+1 (bypass), T+2+lat, or T+2+TIMEOUT
    bit run = 1'b0, pend = 1'b0, byp = 1'b0, tout = 1'b0, chk_rst = 1'b0;
    int m_ptr = 0, m_id = 0, acc_c = 0, rv_at = 0, jm = 0;
    logic [31:0] m_a = '0, m_b = '0, na, nb;
    logic [63:0] e_prod = '0;
    logic e_err = 1'b0, rv;
    logic [NREQ-1:0] exp_rr;
    always @(negedge clk) begin
        exp_rr = '0;
        rv = pend && cyc >= rv_at;
        if (run) begin
            if (!pend)
                for (int k = 0; k < NREQ; k++) begin
                    jm = (m_ptr + k) % NREQ;
                    if (exp_rr == '0 && bus.req_valid[jm]) exp_rr[jm] = 1'b1;
                end
            chk("req_ready", bus.req_ready, exp_rr);
            chk("busy", bus.busy, pend);
            chk("resp_valid", bus.resp_valid, rv);
            chk("mul_start", bus.mul_start, pend && !byp && cyc == acc_c + 1);
            chk("mul_multiplicand", bus.mul_multiplicand, m_a);
            chk("mul_multiplier", bus.mul_multiplier, m_b);
            if (rv) begin
                chk("resp_id", bus.resp_id, m_id);
                chk("resp_product", bus.resp_product, e_prod);
                chk("resp_error", bus.resp_error, e_err);
            end
            if (chk_rst) begin
                chk("rst_resp_id", bus.resp_id, 0);
                chk("rst_resp_product", bus.resp_product, 0);
                chk("rst_resp_error", bus.resp_error, 0);
                chk_rst = 1'b0;
            end
        end
        if (rst) begin
            run = 1'b1;
            pend = 1'b0;
            m_ptr = 0;
            m_a = '0;
            m_b = '0;
            chk_rst = 1'b1;
        end else if (run) begin
            if (!pend && exp_rr != '0) begin
                for (int k = 0; k < NREQ; k++) if (exp_rr[k]) m_id = k;
                na = bus.req_a[32*m_id +: 32];
                nb = bus.req_b[32*m_id +: 32];
                m_a = na;
                m_b = nb;
                byp = (na == 0 || nb == 0);
                tout = never;
                e_prod = (byp || tout) ? 64'd0 : 64'(na) * 64'(nb);
                e_err = !byp && tout;
                acc_c = cyc;
                rv_at = byp ? cyc + 1 : tout ? cyc + 2 + TIMEOUT : cyc + 2 + lat;
                m_ptr = (m_id + 1) % NREQ;
                pend = 1'b1;
            end else if (rv && bus.resp_ready) begin
                pend = 1'b0;
            end
        end
        if (bus.mul_start === 1'b1) starts++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic request(input int i, input logic [31:0] a, input logic [31:0] b, output int acc);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_valid[i] = 1'b1;
        acc = -1;
        for (int k = 0; k < 300 && acc < 0; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) acc = cyc;
        end
        chk("grant_seen", acc >= 0, 1);
        tick();
        bus.req_valid[i] = 1'b0;
    endtask
    task automatic wait_resp(output int c);
        c = -1;
        for (int k = 0; k < 300 && c < 0; k++) begin
            @(negedge clk);
            if (bus.resp_valid) c = cyc;
        end
        chk("resp_seen", c >= 0, 1);
    endtask
    logic [31:0] ta [NREQ] = '{32'h11111111, 32'h22222222, 32'h00000003, 32'hFFFFFFFF};
    logic [31:0] tb [NREQ] = '{32'h0F0F0F0F, 32'h00000010, 32'hABCDEF01, 32'h00000002};
    initial begin
        int acc, c, n, g, s0, hid, nresp;
        logic [63:0] hprod;
        logic herr;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_resp_valid", bus.resp_valid, 0);
        lat = 33;
        request(2, 32'h0000FFFF, 32'h00010001, acc);
        wait_resp(c);
        chk("single_latency", c - acc, 35);
        chk("single_product", bus.resp_product, 64'h00000000FFFFFFFF);
        chk("single_id", bus.resp_id, 2);
        chk("single_error", bus.resp_error, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 5;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = ta[i];
            bus.req_b[32*i +: 32] = tb[i];
        end
        bus.req_valid = '1;
        n = 0;
        for (int k = 0; k < 400 && n < 5; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                chk("rr_onehot", $countones(bus.req_ready), 1);
                g = -1;
                for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) g = j;
                chk("rr_order", g, n % NREQ);
                n++;
            end
        end
        chk("rr_grants", n, 5);
        tick();
        bus.req_valid = '0;
        wait_resp(c);
        tick();
        s0 = starts;
        request(1, 32'h0, 32'hDEADBEEF, acc);
        wait_resp(c);
        chk("bypass_latency", c - acc, 1);
        chk("bypass_product", bus.resp_product, 0);
        tick();
        chk("bypass_no_start", starts, s0);
        request(0, 32'hFFFFFFFF, 32'hFFFFFFFF, acc);
        wait_resp(c);
        chk("stale_latency", c - acc, 7);
        chk("stale_product", bus.resp_product, 64'hFFFFFFFE00000001);
        tick();
        never = 1'b1;
        request(3, 32'd3, 32'd5, acc);
        wait_resp(c);
        chk("timeout_latency", c - acc, 50);
        chk("timeout_error", bus.resp_error, 1);
        chk("timeout_product", bus.resp_product, 0);
        never = 1'b0;
        tick();
        request(1, 32'd7, 32'd9, acc);
        wait_resp(c);
        chk("after_timeout_product", bus.resp_product, 63);
        chk("after_timeout_error", bus.resp_error, 0);
        tick();
        bus.resp_ready = 1'b0;
        lat = 4;
        request(2, 32'd5, 32'd6, acc);
        wait_resp(c);
        hid = int'(bus.resp_id);
        hprod = bus.resp_product;
        herr = bus.resp_error;
        chk("bp_product", hprod, 30);
        tick();
        bus.req_a[31:0] = 32'd7;
        bus.req_b[31:0] = 32'd8;
        bus.req_valid[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_id_stable", bus.resp_id, hid);
            chk("bp_product_stable", bus.resp_product, hprod);
            chk("bp_error_stable", bus.resp_error, herr);
            chk("bp_no_grant", bus.req_ready, 0);
        end
        tick();
        bus.resp_ready = 1'b1;
        request(0, 32'd7, 32'd8, acc);
        wait_resp(c);
        chk("bp_next_product", bus.resp_product, 56);
        tick();
        lat = 33;
        request(2, 32'd11, 32'd13, acc);
        repeat (10) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("wait_rst_busy", bus.busy, 0);
        chk("wait_rst_resp_valid", bus.resp_valid, 0);
        chk("wait_rst_multiplicand", bus.mul_multiplicand, 0);
        tick();
        lat = 5;
        bus.req_a[63:32] = 32'd2;
        bus.req_b[63:32] = 32'd3;
        bus.req_a[127:96] = 32'd4;
        bus.req_b[127:96] = 32'd5;
        bus.req_valid = 4'b1010;
        g = -1;
        for (int k = 0; k < 50 && g < 0; k++) begin
            @(negedge clk);
            for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) g = j;
        end
        chk("ptr_after_rst", g, 1);
        tick();
        bus.req_valid = '0;
        wait_resp(c);
        chk("post_rst_product", bus.resp_product, 6);
        tick();
        nresp = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid) nresp++;
        end
        chk("no_stray_resp", nresp, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one 32x32 sequential shift-add multiplier among NREQ requesters. It sits between the requester ports and the multiplier. It accepts one operand pair at a time, pulses the multiplier's start, tracks its finish flag with a timeout, and returns the 64-bit product tagged with the requester id. Zero operands bypass the multiplier.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- TIMEOUT, default 48: maximum cycles spent in ARM+WAIT before an error response.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  32*NREQ  multiplicands; requester i uses bits [32i+31:32i].
- req_b  in  32*NREQ  multipliers; same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept.
- resp_valid  out  1  response available.
- resp_id  out  clog2(NREQ)  requester id of the response.
- resp_product  out  64  unsigned product.
- resp_error  out  1  timeout flag; resp_product is 0 when set.
- resp_ready  in  1  response consumer ready.
- mul_start  out  1  single-cycle start pulse to the multiplier.
- mul_multiplicand  out  32  latched operand a.
- mul_multiplier  out  32  latched operand b.
- mul_product  in  64  multiplier result.
- mul_finish  in  1  multiplier done level; stays high until the next start.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE:
  - Round-robin search starts at pointer ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 wins, and req_ready[i]=1 combinationally in the same cycle. All other req_ready bits are 0.
  - req_ready is 0 in every other state.
- Accept cycle (IDLE with a winner), at the clock edge:
  - Latch a, b and id. Set ptr = (id+1) mod NREQ.
  - If a==0 or b==0: product=0, error=0, go to RESP (bypass, multiplier untouched).
  - Otherwise go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle. Go to ARM and clear the timeout counter.
- ARM: wait for mul_finish==0, which discards a stale finish from the previous operation. On seeing it, go to WAIT.
- WAIT: on mul_finish==1, latch mul_product and go to RESP with error=0.
- Timeout:
  - The counter increments every cycle in ARM and WAIT.
  - If the counter reaches TIMEOUT-1 without the exit condition, go to RESP with product=0 and error=1.
  - A finish in that same cycle wins over the timeout.
- RESP: resp_valid=1 with resp_id, resp_product and resp_error held stable. When resp_ready=1, go to IDLE.
- A new request can be accepted in the cycle after the RESP handshake, never in the same cycle.
- mul_multiplicand and mul_multiplier hold the latched operands from the accept edge until the next accept.
- Width rule: unsigned only, no truncation; resp_product equals a*b mod 2^64, which is exact.
- Requesters must hold req_valid and the operands until they see req_ready. Dropping req_valid before grant is legal and simply withdraws the request.
- Reset values: state=IDLE, ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_product=0, resp_error=0, mul_start=0, mul_multiplicand=0, mul_multiplier=0, busy=0.
- Reset asserted in any state aborts the operation and discards the in-flight result. The multiplier is not reset; the next ISSUE restarts it.

## Timing
- Accept at the edge ending cycle T gives:
  - mul_start high in T+1.
  - ARM entered in T+2.
- Multiplier model with latency L≥2 (finish low from start+1, high at start+L): resp_valid first high in cycle T+2+L.
- Bypass: resp_valid high in T+1.
- Timeout: resp_valid with error high in T+3+TIMEOUT-1 = T+2+TIMEOUT, measured from ARM entry.
- Back-to-back throughput: one operation per L+3 cycles when resp_ready is held at 1.
- All outputs are registered except req_ready, which is combinational from state, ptr and req_valid.

## Test plan
- Single request 0x0000FFFF × 0x00010001 from requester 2, model L=33, resp_ready=1:
  - resp_valid at accept+35.
  - product 0x00000000FFFFFFFF, id=2, error=0.
- All four requesters valid continuously, resp_ready=1:
  - Grants go 0,1,2,3,0.
  - Each product matches its own operands; exactly one req_ready bit per grant.
- Bypass: a=0, b=0xDEADBEEF:
  - resp_valid at accept+1, product 0.
  - mul_start never pulses.
- Stale finish: finish held high before start and model L=5. The response must carry the new product (0xFFFFFFFF×0xFFFFFFFF=0xFFFFFFFE00000001), not the old one.
- Timeout: model never raises finish, TIMEOUT=48:
  - resp_error=1 and product=0 at ARM entry+48.
  - The next request completes normally.
- Backpressure and reset:
  - resp_ready low for 10 cycles: response fields stay stable and req_ready stays 0.
  - rst pulse during WAIT: all outputs return to their reset values next cycle, ptr=0, and no response is emitted.
